// File: rtl/stim_pkg.sv
// Shared types for the scripted stimulus controller: ROM entry layout,
// key-press action codes and the sequencer state encoding.
package stim_pkg;

    localparam int DUR_W        = 16;
    localparam int STIM_ENTRY_W = 34;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_MODE = 2'd1,
        ACT_TRIP = 2'd2,
        ACT_BOTH = 2'd3
    } stim_action_t;

    typedef struct packed {
        logic [7:0]       fork_code;
        logic [7:0]       crank_code;
        stim_action_t     action;
        logic [DUR_W-1:0] dur;
    } stim_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_APPLY = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } stim_state_t;

    function automatic stim_entry_t make_entry(input logic [7:0] f, input logic [7:0] c,
                                               input stim_action_t a, input logic [DUR_W-1:0] d);
        make_entry = stim_entry_t'{fork_code: f, crank_code: c, action: a, dur: d};
    endfunction

endpackage

// File: rtl/stim_scheduler_rom.sv
// Registered script ROM. PROFILE 0 is a single Mode-press ride segment followed
// by a terminator; PROFILE 1 is a full eight-step ride with no terminator.
module stim_rom
    import stim_pkg::*;
#(
    parameter int STEPS   = 8,
    parameter int PROFILE = 0
) (
    input  logic                      CLK,
    input  logic                      core_nReset,
    input  logic [$clog2(STEPS)-1:0]  addr,
    output logic [STIM_ENTRY_W-1:0]   data
);

    stim_entry_t data_d;
    stim_entry_t data_q;

    // Unlisted addresses read as all-zero, which doubles as the end-of-script marker.
    always_comb begin
        data_d = '0;
        if (PROFILE == 0) begin
            case (int'(addr))
                0:       data_d = make_entry(8'hA0, 8'h50, ACT_MODE, 16'd100);
                default: data_d = '0;
            endcase
        end else begin
            case (int'(addr))
                0:       data_d = make_entry(8'h11, 8'h21, ACT_BOTH, 16'd20);
                1:       data_d = make_entry(8'h12, 8'h22, ACT_NONE, 16'd3);
                2:       data_d = make_entry(8'h13, 8'h23, ACT_TRIP, 16'd1);
                3:       data_d = make_entry(8'h14, 8'h24, ACT_MODE, 16'd60);
                4:       data_d = make_entry(8'h15, 8'h25, ACT_NONE, 16'd2);
                5:       data_d = make_entry(8'h16, 8'h26, ACT_NONE, 16'd2);
                6:       data_d = make_entry(8'h17, 8'h27, ACT_NONE, 16'd2);
                7:       data_d = make_entry(8'h18, 8'h28, ACT_NONE, 16'd2);
                default: data_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge core_nReset) begin
        if (!core_nReset) data_q <= '0;
        else              data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/stim_scheduler.sv
// Script sequencer that arbitrates fork/crank period codes and Mode/Trip keys
// between the manual switch path and the script ROM.
module stim_scheduler #(
    parameter int STEPS       = 8,
    parameter int PRESS_TICKS = 50,
    parameter int DUR_W       = 16,
    parameter int PROFILE     = 0
) (
    input  logic                     CLK,
    input  logic                     core_nReset,
    input  logic                     tick,
    input  logic                     run_en,
    input  logic                     start,
    input  logic [7:0]               manual_fork,
    input  logic [7:0]               manual_crank,
    input  logic                     manual_nMode,
    input  logic                     manual_nTrip,
    output logic [7:0]               forkinput,
    output logic [7:0]               crankinput,
    output logic                     nMode_out,
    output logic                     nTrip_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(STEPS)-1:0] step
);
    import stim_pkg::*;

    localparam int SW = $clog2(STEPS);
    localparam int PW = $clog2(PRESS_TICKS + 1);

    stim_state_t                 state_q, state_d;
    logic        [SW-1:0]        step_q, step_d;
    logic        [DUR_W-1:0]     dur_q, dur_d;
    logic        [PW-1:0]        press_q, press_d;
    stim_action_t                action_q, action_d;
    logic        [7:0]           fork_q, fork_d, crank_q, crank_d;
    logic        [7:0]           fork_out_q, fork_out_d, crank_out_q, crank_out_d;
    logic                        start_prev_q, start_prev_d;
    logic [STIM_ENTRY_W-1:0]     rom_bits;
    stim_entry_t                 rom_data;

    stim_rom #(.STEPS(STEPS), .PROFILE(PROFILE)) u_rom (
        .CLK        (CLK),
        .core_nReset(core_nReset),
        .addr       (step_q),
        .data       (rom_bits)
    );

    assign rom_data = stim_entry_t'(rom_bits);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        dur_d        = dur_q;
        press_d      = press_q;
        action_d     = action_q;
        fork_d       = fork_q;
        crank_d      = crank_q;
        start_prev_d = start;
        case (state_q)
            ST_IDLE: if (run_en && start && !start_prev_q) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_APPLY;
            ST_APPLY: begin
                if (rom_data.dur == '0) begin
                    state_d = ST_DONE;
                end else begin
                    fork_d   = rom_data.fork_code;
                    crank_d  = rom_data.crank_code;
                    dur_d    = rom_data.dur;
                    press_d  = (rom_data.action != ACT_NONE) ? PW'(PRESS_TICKS) : '0;
                    action_d = rom_data.action;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    dur_d = dur_q - 1'b1;
                    if (press_q != '0) press_d = press_q - 1'b1;
                    // Last tick of the step: a press longer than the step is cut short here.
                    if (dur_q == DUR_W'(1)) begin
                        press_d = '0;
                        if (step_q == SW'(STEPS - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            step_d  = step_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (!run_en) begin
            state_d = ST_IDLE;
            step_d  = '0;
            press_d = '0;
        end
    end

    assign busy = (state_q == ST_FETCH) || (state_q == ST_APPLY) || (state_q == ST_HOLD);
    assign done = (state_q == ST_DONE);

    // Source select follows the current state, so an abort reverts the codes one cycle
    // after the FSM has already returned to IDLE; the value taken is the freshly latched one.
    always_comb begin
        fork_out_d  = (busy || done) ? fork_d  : manual_fork;
        crank_out_d = (busy || done) ? crank_d : manual_crank;
    end

    always_ff @(posedge CLK or negedge core_nReset) begin
        if (!core_nReset) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            dur_q        <= '0;
            press_q      <= '0;
            action_q     <= ACT_NONE;
            fork_q       <= '0;
            crank_q      <= '0;
            fork_out_q   <= '0;
            crank_out_q  <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            dur_q        <= dur_d;
            press_q      <= press_d;
            action_q     <= action_d;
            fork_q       <= fork_d;
            crank_q      <= crank_d;
            fork_out_q   <= fork_out_d;
            crank_out_q  <= crank_out_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign forkinput  = fork_out_q;
    assign crankinput = crank_out_q;
    assign step       = step_q;
    // Keys are gated straight from the press register so an async reset releases them at once.
    assign nMode_out  = manual_nMode & ~((press_q != '0) & action_q[0]);
    assign nTrip_out  = manual_nTrip & ~((press_q != '0) & action_q[1]);

endmodule

// File: tb/tb_stim_scheduler.sv
// Directed bench for stim_scheduler: instance a runs the single-step profile with
// terminator, instance b runs the full eight-step profile.
module tb_stim_scheduler;

    logic       CLK = 1'b0;
    logic       core_nReset = 1'b0;
    logic       tick = 1'b1;
    logic       run_en_a = 1'b0, start_a = 1'b0, run_en_b = 1'b0, start_b = 1'b0;
    logic [7:0] manual_fork = 8'h12, manual_crank = 8'h34;
    logic       manual_nMode = 1'b1, manual_nTrip = 1'b1;

    logic [7:0] fork_a, crank_a, fork_b, crank_b;
    logic       nMode_a, nTrip_a, busy_a, done_a, nMode_b, nTrip_b, busy_b, done_b;
    logic [2:0] step_a, step_b;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    stim_scheduler #(.STEPS(8), .PRESS_TICKS(50), .DUR_W(16), .PROFILE(0)) dut_a (
        .CLK(CLK), .core_nReset(core_nReset), .tick(tick), .run_en(run_en_a), .start(start_a),
        .manual_fork(manual_fork), .manual_crank(manual_crank),
        .manual_nMode(manual_nMode), .manual_nTrip(manual_nTrip),
        .forkinput(fork_a), .crankinput(crank_a), .nMode_out(nMode_a), .nTrip_out(nTrip_a),
        .busy(busy_a), .done(done_a), .step(step_a)
    );

    stim_scheduler #(.STEPS(8), .PRESS_TICKS(50), .DUR_W(16), .PROFILE(1)) dut_b (
        .CLK(CLK), .core_nReset(core_nReset), .tick(tick), .run_en(run_en_b), .start(start_b),
        .manual_fork(manual_fork), .manual_crank(manual_crank),
        .manual_nMode(manual_nMode), .manual_nTrip(manual_nTrip),
        .forkinput(fork_b), .crankinput(crank_b), .nMode_out(nMode_b), .nTrip_out(nTrip_b),
        .busy(busy_b), .done(done_b), .step(step_b)
    );

    task automatic step_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        manual_nMode = 1'b0;
        #3;
        checks++; if (nMode_a !== 1'b0) $display("FAIL rst_nmode_follow: got %b want 0", nMode_a); else passed++;
        checks++; if (nTrip_a !== 1'b1) $display("FAIL rst_ntrip: got %b want 1", nTrip_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL rst_done: got %b want 0", done_a); else passed++;
        checks++; if (step_a !== 3'd0) $display("FAIL rst_step: got %0d want 0", step_a); else passed++;
        manual_nMode = 1'b1;
        @(negedge CLK);
        core_nReset = 1'b1;
        step_clk(2);
        checks++; if (fork_a !== 8'h12) $display("FAIL rst_fork: got %h want 12", fork_a); else passed++;
        checks++; if (crank_a !== 8'h34) $display("FAIL rst_crank: got %h want 34", crank_a); else passed++;
        checks++; if (fork_b !== 8'h12) $display("FAIL rst_fork_b: got %h want 12", fork_b); else passed++;
        checks++; if (nMode_a !== 1'b1) $display("FAIL rst_nmode: got %b want 1", nMode_a); else passed++;
    endtask

    task automatic test_start_disarmed;
        @(negedge CLK);
        start_a = 1'b1;
        step_clk(5);
        checks++; if (busy_a !== 1'b0) $display("FAIL disarmed_busy: got %b want 0", busy_a); else passed++;
        checks++; if (fork_a !== 8'h12) $display("FAIL disarmed_fork: got %h want 12", fork_a); else passed++;
        start_a = 1'b0;
        step_clk(2);
    endtask

    task automatic test_single_step;
        int n;
        int e;
        @(negedge CLK);
        run_en_a = 1'b1;
        start_a  = 1'b1;
        step_clk(2);
        checks++; if (nMode_a !== 1'b1) $display("FAIL lat_early_nmode: got %b want 1", nMode_a); else passed++;
        checks++; if (busy_a !== 1'b1) $display("FAIL lat_busy: got %b want 1", busy_a); else passed++;
        step_clk(1);
        checks++; if (fork_a !== 8'hA0) $display("FAIL lat_fork: got %h want a0", fork_a); else passed++;
        checks++; if (crank_a !== 8'h50) $display("FAIL lat_crank: got %h want 50", crank_a); else passed++;
        checks++; if (nMode_a !== 1'b0) $display("FAIL lat_nmode: got %b want 0", nMode_a); else passed++;
        n = 1;
        for (int i = 0; i < 200; i++) begin
            step_clk(1);
            if (nMode_a === 1'b0) n++;
            else break;
        end
        checks++; if (n != 50) $display("FAIL mode_press_len: got %0d want 50", n); else passed++;
        e = n;
        while (step_a !== 3'd1 && e < 300) begin
            step_clk(1);
            e++;
        end
        checks++; if (e != 100) $display("FAIL step0_len: got %0d want 100", e); else passed++;
        step_clk(1);
        checks++; if (done_a !== 1'b0) $display("FAIL done_early: got %b want 0", done_a); else passed++;
        step_clk(1);
        checks++; if (done_a !== 1'b1) $display("FAIL term_done: got %b want 1", done_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL term_busy: got %b want 0", busy_a); else passed++;
        checks++; if (fork_a !== 8'hA0) $display("FAIL term_fork: got %h want a0", fork_a); else passed++;
        checks++; if (crank_a !== 8'h50) $display("FAIL term_crank: got %h want 50", crank_a); else passed++;
        start_a = 1'b0;
        step_clk(1);
        start_a = 1'b1;
        step_clk(3);
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL done_restart: got done=%b busy=%b want 1/0", done_a, busy_a); else passed++;
        run_en_a = 1'b0;
        step_clk(1);
        checks++; if (step_a !== 3'd0) $display("FAIL exit_step: got %0d want 0", step_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL exit_done: got %b want 0", done_a); else passed++;
        checks++; if (fork_a !== 8'hA0) $display("FAIL exit_fork_hold: got %h want a0", fork_a); else passed++;
        step_clk(1);
        checks++; if (fork_a !== 8'h12) $display("FAIL exit_fork: got %h want 12", fork_a); else passed++;
        checks++; if (crank_a !== 8'h34) $display("FAIL exit_crank: got %h want 34", crank_a); else passed++;
        start_a = 1'b0;
        step_clk(2);
    endtask

    task automatic test_abort;
        tick = 1'b0;
        @(negedge CLK);
        run_en_a = 1'b1;
        start_a  = 1'b1;
        step_clk(3);
        checks++; if (nMode_a !== 1'b0) $display("FAIL abort_press: got %b want 0", nMode_a); else passed++;
        step_clk(60);
        checks++; if (nMode_a !== 1'b0) $display("FAIL notick_press: got %b want 0", nMode_a); else passed++;
        checks++; if (busy_a !== 1'b1) $display("FAIL notick_busy: got %b want 1", busy_a); else passed++;
        run_en_a = 1'b0;
        step_clk(1);
        checks++; if (nMode_a !== 1'b1) $display("FAIL abort_release: got %b want 1", nMode_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_a); else passed++;
        checks++; if (fork_a !== 8'hA0) $display("FAIL abort_fork_hold: got %h want a0", fork_a); else passed++;
        step_clk(1);
        checks++; if (fork_a !== 8'h12) $display("FAIL abort_fork: got %h want 12", fork_a); else passed++;
        tick = 1'b1;
        start_a = 1'b0;
        step_clk(2);
    endtask

    task automatic test_reset_mid_hold;
        @(negedge CLK);
        run_en_a = 1'b1;
        start_a  = 1'b1;
        step_clk(10);
        checks++; if (nMode_a !== 1'b0) $display("FAIL mid_press: got %b want 0", nMode_a); else passed++;
        #2;
        core_nReset = 1'b0;
        #1;
        checks++; if (nMode_a !== 1'b1) $display("FAIL arst_release: got %b want 1", nMode_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy_a); else passed++;
        @(negedge CLK);
        core_nReset = 1'b1;
        run_en_a = 1'b0;
        start_a  = 1'b0;
        step_clk(2);
    endtask

    task automatic test_full_script;
        int n;
        int e;
        @(negedge CLK);
        run_en_b = 1'b1;
        start_b  = 1'b1;
        step_clk(3);
        checks++; if (fork_b !== 8'h11 || crank_b !== 8'h21) $display("FAIL both_codes: got %h/%h want 11/21", fork_b, crank_b); else passed++;
        checks++; if (nMode_b !== 1'b0 || nTrip_b !== 1'b0) $display("FAIL both_keys: got %b/%b want 0/0", nMode_b, nTrip_b); else passed++;
        start_b = 1'b0;
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step_clk(1);
            if (i == 1) start_b = 1'b1;
            if (nMode_b === 1'b0 && nTrip_b === 1'b0) n++;
            else break;
        end
        checks++; if (n != 20) $display("FAIL both_len: got %0d want 20", n); else passed++;
        checks++; if (step_b !== 3'd1) $display("FAIL both_boundary_step: got %0d want 1", step_b); else passed++;
        checks++; if (nMode_b !== 1'b1 || nTrip_b !== 1'b1) $display("FAIL both_release: got %b/%b want 1/1", nMode_b, nTrip_b); else passed++;
        for (int i = 0; i < 20; i++) begin
            if (nTrip_b === 1'b0) break;
            step_clk(1);
        end
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step_clk(1);
            if (nTrip_b === 1'b0) n++;
            else break;
        end
        checks++; if (n != 1) $display("FAIL dur1_trip_len: got %0d want 1", n); else passed++;
        for (int i = 0; i < 20; i++) begin
            if (nMode_b === 1'b0) break;
            step_clk(1);
        end
        n = 1;
        for (int i = 0; i < 100; i++) begin
            step_clk(1);
            if (nMode_b === 1'b0) n++;
            else break;
        end
        checks++; if (n != 50) $display("FAIL step3_mode_len: got %0d want 50", n); else passed++;
        manual_nTrip = 1'b0;
        #1;
        checks++; if (nTrip_b !== 1'b0) $display("FAIL manual_trip_pass: got %b want 0", nTrip_b); else passed++;
        checks++; if (busy_b !== 1'b1) $display("FAIL manual_trip_busy: got %b want 1", busy_b); else passed++;
        manual_nTrip = 1'b1;
        e = 0;
        while (done_b !== 1'b1 && e < 100) begin
            step_clk(1);
            e++;
        end
        checks++; if (e != 26) $display("FAIL full_done_time: got %0d want 26", e); else passed++;
        checks++; if (step_b !== 3'd7) $display("FAIL full_step: got %0d want 7", step_b); else passed++;
        checks++; if (fork_b !== 8'h18 || crank_b !== 8'h28) $display("FAIL full_codes: got %h/%h want 18/28", fork_b, crank_b); else passed++;
        checks++; if (busy_b !== 1'b0) $display("FAIL full_busy: got %b want 0", busy_b); else passed++;
        run_en_b = 1'b0;
        start_b  = 1'b0;
        step_clk(2);
        checks++; if (step_b !== 3'd0 || done_b !== 1'b0) $display("FAIL full_exit: got step=%0d done=%b want 0/0", step_b, done_b); else passed++;
        checks++; if (fork_b !== 8'h12) $display("FAIL full_exit_fork: got %h want 12", fork_b); else passed++;
    endtask

    initial begin
        test_reset();
        test_start_disarmed();
        test_single_step();
        test_abort();
        test_reset_mid_hold();
        test_full_script();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
